// File: rtl/bp_lite_to_stream_pkg.sv
// Shared BedRock-lite types for the lite-to-stream converter: processor configs, message type/size enums and width helpers.
// The optional critical-word-first wrap feature is selected with BP_LITE_TO_STREAM_WRAP_EN.
package bp_lite_to_stream_pkg;

   typedef enum logic [1:0] {
      e_bp_default_cfg = 2'd0,
      e_bp_small_cfg   = 2'd1
   } bp_params_e;

   typedef enum logic [3:0] {
      e_bedrock_mem_rd    = 4'd0,
      e_bedrock_mem_wr    = 4'd1,
      e_bedrock_mem_uc_rd = 4'd2,
      e_bedrock_mem_uc_wr = 4'd3,
      e_bedrock_mem_pre   = 4'd4,
      e_bedrock_mem_amo   = 4'd5
   } bp_bedrock_mem_type_e;

   typedef enum logic [2:0] {
      e_bedrock_msg_size_1   = 3'd0,
      e_bedrock_msg_size_2   = 3'd1,
      e_bedrock_msg_size_4   = 3'd2,
      e_bedrock_msg_size_8   = 3'd3,
      e_bedrock_msg_size_16  = 3'd4,
      e_bedrock_msg_size_32  = 3'd5,
      e_bedrock_msg_size_64  = 3'd6,
      e_bedrock_msg_size_128 = 3'd7
   } bp_bedrock_msg_size_e;

   localparam int msg_type_width_gp = 4;
   localparam int subop_width_gp    = 4;
   localparam int msg_size_width_gp = 3;

   function automatic int paddr_width(input bp_params_e cfg);
      case (cfg)
         e_bp_default_cfg: return 40;
         e_bp_small_cfg:   return 32;
         default:          return 40;
      endcase
   endfunction

   function automatic int lce_id_width(input bp_params_e cfg);
      case (cfg)
         e_bp_default_cfg: return 4;
         e_bp_small_cfg:   return 2;
         default:          return 4;
      endcase
   endfunction

   function automatic int lce_assoc(input bp_params_e cfg);
      case (cfg)
         e_bp_default_cfg: return 8;
         e_bp_small_cfg:   return 4;
         default:          return 8;
      endcase
   endfunction

endpackage

// File: rtl/bp_me_stream_addr_gen.sv
// Beat counter and per-beat address generator for the lite-to-stream converter.
// BP_LITE_TO_STREAM_WRAP_EN selects critical-word-first wrapping inside the 2^size block; otherwise addresses run linearly.
module bp_me_stream_addr_gen
   import bp_lite_to_stream_pkg::*;
#(
   parameter int paddr_width_p = 40,
   parameter int beat_bytes_p  = 8,
   parameter int max_beats_p   = 8,
   localparam int cnt_width_lp = (max_beats_p > 1) ? $clog2(max_beats_p) : 1
)
(
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic [paddr_width_p-1:0]  addr_i,
   input  bp_bedrock_msg_size_e      size_i,
   input  logic                      has_data_i,
   input  logic                      advance_i,
   output logic [cnt_width_lp-1:0]   cnt_o,
   output logic                      last_o,
   output logic [paddr_width_p-1:0]  addr_o
);

   localparam int beat_log_lp = $clog2(beat_bytes_p);
   localparam int max_log_lp  = $clog2(max_beats_p);

   logic [cnt_width_lp-1:0]  cnt_r;
   logic [cnt_width_lp-1:0]  last_beat_s;
   logic [paddr_width_p-1:0] offset_s;
   logic [paddr_width_p-1:0] mask_s;
   int                       beats_log_s;

   // log2 of the beat count; data-less or sub-beat messages collapse to a single beat
   always_comb begin
      beats_log_s = 0;
      if (has_data_i && (int'(size_i) > beat_log_lp)) begin
         beats_log_s = int'(size_i) - beat_log_lp;
      end else begin
         beats_log_s = 0;
      end
      beats_log_s = (beats_log_s > max_log_lp) ? max_log_lp : beats_log_s;
      last_beat_s = cnt_width_lp'((1 << beats_log_s) - 1);
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         cnt_r <= '0;
      end else if (advance_i) begin
         cnt_r <= (cnt_r == last_beat_s) ? '0 : cnt_r + 1'b1;
      end
   end

   assign offset_s = paddr_width_p'(cnt_r) << beat_log_lp;
   assign mask_s   = (paddr_width_p'(1) << size_i) - paddr_width_p'(1);

`ifdef BP_LITE_TO_STREAM_WRAP_EN
   assign addr_o = (addr_i & ~mask_s) | ((addr_i + offset_s) & mask_s);
`else
   assign addr_o = addr_i + offset_s;
`endif

   assign cnt_o  = cnt_r;
   assign last_o = (cnt_r == last_beat_s);

endmodule

// File: rtl/bp_lite_to_stream.sv
// Converts one BedRock lite message {header, data} into a stream of beats with per-beat header addresses.
// Define BP_LITE_TO_STREAM_WRAP_EN for critical-word-first wrapped beat addresses.
module bp_lite_to_stream
   import bp_lite_to_stream_pkg::*;
#(
   parameter bp_params_e bp_params_p      = e_bp_default_cfg,
   parameter int         in_data_width_p  = 512,
   parameter int         out_data_width_p = 64,
   parameter int         payload_width_p  = 16,
   parameter int         payload_mask_p   = 0,
   localparam int paddr_width_lp          = paddr_width(bp_params_p),
   localparam int out_msg_header_width_lp = msg_type_width_gp + subop_width_gp + paddr_width_lp
                                            + msg_size_width_gp + payload_width_p,
   localparam int in_msg_width_lp         = out_msg_header_width_lp + in_data_width_p
)
(
   input  logic                               clk_i,
   input  logic                               reset_i,
   input  logic [in_msg_width_lp-1:0]         in_msg_i,
   input  logic                               in_msg_v_i,
   output logic                               in_msg_ready_and_o,
   output logic [out_msg_header_width_lp-1:0] out_msg_header_o,
   output logic [out_data_width_p-1:0]        out_msg_data_o,
   output logic                               out_msg_v_o,
   input  logic                               out_msg_ready_and_i,
   output logic                               out_msg_last_o
);

   localparam int max_beats_lp = in_data_width_p / out_data_width_p;
   localparam int cnt_width_lp = (max_beats_lp > 1) ? $clog2(max_beats_lp) : 1;

   typedef struct packed {
      bp_bedrock_mem_type_e        msg_type;
      logic [subop_width_gp-1:0]   subop;
      logic [paddr_width_lp-1:0]   addr;
      bp_bedrock_msg_size_e        size;
      logic [payload_width_p-1:0]  payload;
   } hdr_s;

   typedef enum logic {e_ready = 1'b0, e_stream = 1'b1} state_e;

`ifndef SYNTHESIS
   if (in_data_width_p <= out_data_width_p) begin : g_chk_ratio
      $error("in_data_width_p must exceed out_data_width_p");
   end
   if ((in_data_width_p % out_data_width_p) != 0) begin : g_chk_div
      $error("in_data_width_p must be a multiple of out_data_width_p");
   end
`endif

   state_e                     state_r;
   logic                       in_ready_r;
   logic                       out_v_r;
   hdr_s                       hdr_r;
   logic [in_data_width_p-1:0] data_r;
   hdr_s                       in_hdr_s;
   hdr_s                       out_hdr_s;
   logic                       accept_s;
   logic                       advance_s;
   logic                       last_s;
   logic [cnt_width_lp-1:0]    cnt_s;
   logic [paddr_width_lp-1:0]  beat_addr_s;

   assign in_hdr_s  = in_msg_i[in_msg_width_lp-1 -: out_msg_header_width_lp];
   assign accept_s  = in_msg_v_i & in_ready_r;
   assign advance_s = out_v_r & out_msg_ready_and_i;

   bp_me_stream_addr_gen #(
      .paddr_width_p (paddr_width_lp),
      .beat_bytes_p  (out_data_width_p / 8),
      .max_beats_p   (max_beats_lp)
   ) addr_gen (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .addr_i     (hdr_r.addr),
      .size_i     (hdr_r.size),
      .has_data_i (payload_mask_p[hdr_r.msg_type]),
      .advance_i  (advance_s),
      .cnt_o      (cnt_s),
      .last_o     (last_s),
      .addr_o     (beat_addr_s)
   );

   // Handshake FSM; ready comes up one cycle after reset releases
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_r    <= e_ready;
         in_ready_r <= 1'b0;
         out_v_r    <= 1'b0;
      end else begin
         case (state_r)
            e_ready: begin
               if (accept_s) begin
                  state_r    <= e_stream;
                  in_ready_r <= 1'b0;
                  out_v_r    <= 1'b1;
               end else begin
                  in_ready_r <= 1'b1;
                  out_v_r    <= 1'b0;
               end
            end
            e_stream: begin
               if (advance_s && last_s) begin
                  state_r    <= e_ready;
                  in_ready_r <= 1'b1;
                  out_v_r    <= 1'b0;
               end
            end
            default: begin
               state_r    <= e_ready;
               in_ready_r <= 1'b0;
               out_v_r    <= 1'b0;
            end
         endcase
      end
   end

   // One-entry message buffer; contents are don't-care until the first capture
   always_ff @(posedge clk_i) begin
      if (accept_s) begin
         hdr_r  <= in_hdr_s;
         data_r <= in_msg_i[in_data_width_p-1:0];
      end
   end

   always_comb begin
      out_hdr_s      = hdr_r;
      out_hdr_s.addr = beat_addr_s;
   end

   assign out_msg_header_o   = out_hdr_s;
   assign out_msg_data_o     = data_r[out_data_width_p*int'(cnt_s) +: out_data_width_p];
   assign out_msg_v_o        = out_v_r;
   assign out_msg_last_o     = out_v_r & last_s;
   assign in_msg_ready_and_o = in_ready_r;

endmodule

// File: tb/tb_bp_lite_to_stream.sv
// Directed table-driven bench for bp_lite_to_stream (512->64, write types carry data).
// Expected addresses follow BP_LITE_TO_STREAM_WRAP_EN when it is defined.
module tb_bp_lite_to_stream;

   localparam int HDR_W = 67;
   localparam int IN_W  = HDR_W + 512;

   typedef struct packed {
      logic [3:0]  msg_type;
      logic [3:0]  subop;
      logic [39:0] addr;
      logic [2:0]  size;
      logic [15:0] payload;
   } hdr_t;

   typedef struct {
      logic [3:0]       mtype;
      logic [2:0]       size;
      logic [39:0]      addr;
      int               beats;
      logic [7:0][39:0] exp_addr;
   } vec_t;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [IN_W-1:0] in_msg = '0;
   logic            in_v = 1'b0;
   logic            in_ready;
   logic [HDR_W-1:0] out_hdr;
   logic [63:0]     out_data;
   logic            out_v;
   logic            out_ready = 1'b1;
   logic            out_last;

   int checks = 0;
   int failures = 0;
   vec_t vecs [6];

   bp_lite_to_stream #(
      .in_data_width_p  (512),
      .out_data_width_p (64),
      .payload_width_p  (16),
      .payload_mask_p   (32'h0000_000A)
   ) dut (
      .clk_i               (clk),
      .reset_i             (reset),
      .in_msg_i            (in_msg),
      .in_msg_v_i          (in_v),
      .in_msg_ready_and_o  (in_ready),
      .out_msg_header_o    (out_hdr),
      .out_msg_data_o      (out_data),
      .out_msg_v_o         (out_v),
      .out_msg_ready_and_i (out_ready),
      .out_msg_last_o      (out_last)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] beat_data(input int vi, input int k);
      return {32'hC0DE_0000 | 32'(vi), 32'(k) * 32'h0101_0101};
   endfunction

   function automatic hdr_t make_hdr(input int vi, input logic [39:0] addr);
      hdr_t h;
      h.msg_type = vecs[vi].mtype;
      h.subop    = 4'(vi);
      h.addr     = addr;
      h.size     = vecs[vi].size;
      h.payload  = 16'hBEE0 + 16'(vi);
      return h;
   endfunction

   function automatic logic [IN_W-1:0] make_msg(input int vi);
      logic [511:0] d;
      for (int k = 0; k < 8; k++) d[k*64 +: 64] = beat_data(vi, k);
      return {make_hdr(vi, vecs[vi].addr), d};
   endfunction

   task automatic check_beat(input int vi, input int k, input string tag);
      chk({tag, "_v"}, 128'(out_v), 128'(1'b1));
      chk({tag, "_hdr"}, 128'(out_hdr), 128'(make_hdr(vi, vecs[vi].exp_addr[k])));
      chk({tag, "_data"}, 128'(out_data), 128'(beat_data(vi, k)));
      chk({tag, "_last"}, 128'(out_last), 128'(k == vecs[vi].beats - 1));
   endtask

   task automatic send(input int vi);
      bit ok;
      @(negedge clk);
      in_msg = make_msg(vi);
      in_v   = 1'b1;
      ok     = 1'b0;
      for (int t = 0; t < 20; t++) begin
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("send_ready", 128'(ok), 128'(1'b1));
      @(posedge clk);
      #1 in_v = 1'b0;
   endtask

   task automatic collect(input int vi, input int stall_at, input int stall_len);
      @(negedge clk);
      for (int k = 0; k < vecs[vi].beats; k++) begin
         if (k == stall_at) begin
            out_ready = 1'b0;
            for (int s = 0; s < stall_len; s++) begin
               check_beat(vi, k, "stall");
               @(negedge clk);
            end
            out_ready = 1'b1;
         end
         check_beat(vi, k, "beat");
         @(negedge clk);
      end
      chk("end_v", 128'(out_v), 128'(1'b0));
      chk("end_ready", 128'(in_ready), 128'(1'b1));
   endtask

   initial begin
      vecs[0] = '{4'd1, 3'd6, 40'h1010, 8,
`ifdef BP_LITE_TO_STREAM_WRAP_EN
         {40'h1008, 40'h1000, 40'h1038, 40'h1030, 40'h1028, 40'h1020, 40'h1018, 40'h1010}};
`else
         {40'h1048, 40'h1040, 40'h1038, 40'h1030, 40'h1028, 40'h1020, 40'h1018, 40'h1010}};
`endif
      vecs[1] = '{4'd0, 3'd6, 40'h1010, 1, {280'h0, 40'h1010}};
      vecs[2] = '{4'd1, 3'd3, 40'h2004, 1, {280'h0, 40'h2004}};
      vecs[3] = '{4'd1, 3'd0, 40'h3003, 1, {280'h0, 40'h3003}};
`ifdef BP_LITE_TO_STREAM_WRAP_EN
      vecs[4] = '{4'd3, 3'd4, 40'h4018, 2, {240'h0, 40'h4010, 40'h4018}};
`else
      vecs[4] = '{4'd3, 3'd4, 40'h4018, 2, {240'h0, 40'h4020, 40'h4018}};
`endif
      vecs[5] = '{4'd3, 3'd5, 40'h5000, 4, {160'h0, 40'h5018, 40'h5010, 40'h5008, 40'h5000}};

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_v", 128'(out_v), 128'(1'b0));
      chk("rst_ready", 128'(in_ready), 128'(1'b0));
      chk("rst_last", 128'(out_last), 128'(1'b0));
      reset = 1'b0;

      for (int i = 0; i < 6; i++) begin
         send(i);
         collect(i, -1, 0);
      end

      // backpressure mid-message
      send(0);
      collect(0, 3, 3);

      // asynchronous reset at beat 4 of 8, then a fresh message from beat 0
      send(0);
      repeat (4) @(negedge clk);
      chk("pre_rst_addr", 128'(out_hdr), 128'(make_hdr(0, vecs[0].exp_addr[3])));
      reset = 1'b1;
      #1;
      chk("async_rst_v", 128'(out_v), 128'(1'b0));
      chk("async_rst_ready", 128'(in_ready), 128'(1'b0));
      chk("async_rst_last", 128'(out_last), 128'(1'b0));
      @(negedge clk);
      reset = 1'b0;
      send(4);
      collect(4, -1, 0);

      // back-to-back with in_msg_v_i held high
      send(5);
      in_v = 1'b1;
      in_msg = make_msg(4);
      collect(5, -1, 0);
      @(posedge clk);
      #1 in_v = 1'b0;
      collect(4, -1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bp_lite_to_stream.md
BP_LITE_TO_STREAM -- requirements
Module: bp_lite_to_stream

Interface
REQ-001 The block SHALL have parameter bp_params_p, default e_bp_default_cfg, selecting the processor configuration (paddr_width_p, lce_id_width_p, lce_assoc_p).
REQ-002 The block SHALL have parameter in_data_width_p, default "inv", giving the lite message data width in bits.
REQ-003 The block SHALL have parameter out_data_width_p, default "inv", giving the stream beat data width in bits.
REQ-004 The block SHALL have parameter payload_width_p, default "inv", giving the BedRock header payload width.
REQ-005 The block SHALL have parameter payload_mask_p, default 0, a bitmask (1 << msg_type) of message types carrying data.
REQ-006 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-007 reset_i  input  1  asynchronous, active-high reset.
REQ-008 in_msg_i  input  in_msg_width_lp  lite message {header, data}.
REQ-009 in_msg_v_i / in_msg_ready_and_o  input / output  1 / 1  lite ready-valid-and handshake.
REQ-010 out_msg_header_o  output  out_msg_header_width_lp  per-beat header.
REQ-011 out_msg_data_o  output  out_data_width_p  beat data.
REQ-012 out_msg_v_o / out_msg_ready_and_i  output / input  1 / 1  stream ready-valid-and handshake.
REQ-013 out_msg_last_o  output  1  high on the final beat of a message.

Function
REQ-014 The FSM SHALL have two states: e_ready (in_msg_ready_and_o=1, out_msg_v_o=0) and e_stream (in_msg_ready_and_o=0, out_msg_v_o=1).
REQ-015 An in_msg_v_i & in_msg_ready_and_o handshake SHALL capture header and data into a one-entry buffer and move the FSM to e_stream on the next edge; latency from acceptance to the first valid beat is one cycle.
REQ-016 Beat count N SHALL be max(1, 2^size / (out_data_width_p/8)) if payload_mask_p[msg_type] is set, else 1.
REQ-017 A beat counter SHALL advance only on out_msg_v_o & out_msg_ready_and_i; out_msg_last_o=1 when counter==N-1.
REQ-018 Beat k SHALL present data slice k (bits k*out_data_width_p +: out_data_width_p) of the buffered data.
REQ-019 The beat header SHALL equal the buffered header with addr replaced by the per-beat address; all other fields held constant.
REQ-020 The handshake on the last beat SHALL return the FSM to e_ready and clear the counter; a new lite message is accepted no earlier than the following cycle.
REQ-021 Outputs SHALL remain stable while out_msg_v_o=1 and out_msg_ready_and_i=0.
REQ-022 Messages with 2^size smaller than one beat SHALL produce one beat with unmodified addr.

Reset
REQ-023 reset_i SHALL immediately force state e_ready, counter 0, out_msg_v_o=0, out_msg_last_o=0, in_msg_ready_and_o=0 while asserted; a message in flight is discarded.
REQ-024 Buffer contents SHALL NOT require reset.

Configuration
REQ-025 With BP_LITE_TO_STREAM_WRAP_EN defined, beat k addr SHALL be base | ((addr + k*beat_bytes) mod 2^size), base being addr aligned down to 2^size (critical-word-first wrap).
REQ-026 Without BP_LITE_TO_STREAM_WRAP_EN, beat k addr SHALL be addr + k*beat_bytes (linear, no wrap).

Structure
REQ-027 Header typedefs, bp_bedrock_msg_size_e and widths SHALL come from bp_me_pkg via the bedrock interface macros; state enum stays local.
REQ-028 Address generation SHALL be a sub-module bp_me_stream_addr_gen (counter + wrap logic).
REQ-029 Simulation-only assertions SHALL check in_data_width_p > out_data_width_p and in_data_width_p % out_data_width_p == 0.

Verification
REQ-030 512->64, payload write, size 64B, addr 0x1010, WRAP_EN -> 8 beats, addrs 0x1010,0x1018,...,0x1038,0x1000,0x1008, last on beat 8.
REQ-031 Same stimulus without WRAP_EN -> addrs 0x1010 through 0x1048 in steps of 8.
REQ-032 Type not in payload_mask_p, size 64B -> exactly one beat, last=1, addr unchanged.
REQ-033 out_msg_ready_and_i low for 3 cycles mid-message -> header, data and last held constant; no beat lost or duplicated.
REQ-034 reset_i asserted at beat 4 of 8 -> out_msg_v_o low without waiting for a clock edge; next message starts at beat 0.
REQ-035 Back-to-back lite messages with in_msg_v_i held high -> second accepted the cycle after first last-beat handshake.
